branch_resolver: RTL and testbench

- Execute-stage partner of the dual-issue fetch/decode predictor.
- Resolves the actual outcome of bne, blt and bex, compares it with the prediction made at decode, and drives the registered feedback bus the predictor trains on.
- On a misprediction it issues a one-shot redirect PC and holds a flush for a fixed number of cycles; wrong-path instructions arriving during the flush are discarded.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_cond_eval.sv | 43 ++++
 rtl/branch_resolver.sv | 133 +++++++++++++
 tb/tb_branch_resolver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver and its helpers.
//   - Opcode constants for the control-flow instructions the resolver sees.
//   - br_fb_t: one predictor feedback record (pc, wrong, predicted_taken, is_branch).
//   - FLUSH_CNT_W: width of the flush down-counter.
package branch_pkg;

  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;
  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;

  localparam int FLUSH_CNT_W = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        wrong;
    logic        predicted_taken;
    logic        is_branch;
  } br_fb_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
//   opcode      : instruction[31:27]
//   opA, opB    : $rd / $rs values (opA is $rstatus for bex)
//   is_branch   : opcode is bne, blt or bex
//   actual_taken: resolved outcome (0 for non-branches)
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        is_branch,
  output logic        actual_taken
);

  // Signed less-than via a 33-bit sign-extended difference: the extra bit
  // absorbs any overflow, so bit 32 is the true sign of opA - opB.
  logic        ltSign;
  logic [31:0] unusedDiffLow;
  assign {ltSign, unusedDiffLow} = {opA[31], opA} - {opB[31], opB};

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    is_branch    = 1'b0;
    actual_taken = 1'b0;
    case (opcode)
      OP_BNE: begin
        is_branch    = 1'b1;
        actual_taken = (opA != opB);
      end
      OP_BLT: begin
        is_branch    = 1'b1;
        actual_taken = ltSign;
      end
      OP_BEX: begin
        is_branch    = 1'b1;
        actual_taken = (opA != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver. Resolves bne/blt/bex, drives the registered
// predictor feedback bus, issues a one-shot redirect on a mispredict and
// holds flush/busy for FLUSH_CYCLES cycles while wrong-path work is dropped.
// Ports:
//   clock, reset (async, active-low)
//   in_*                    : execute-slot instruction and decode prediction
//   predictor_past_*, past_*: feedback for the predictor (latency 1)
//   redirect_valid/pc       : one-cycle fetch redirect
//   flush, busy             : high while in FLUSH
// Optional: define BRANCH_RESOLVER_PERF_EN to add saturating perf_branches
// and perf_mispredicts counters.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [4:0]      in_opcode,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_opA,
  input  logic [31:0]     in_opB,
  input  logic [PC_W-1:0] in_target,
  input  logic            in_predicted_taken,
  output logic [PC_W-1:0] predictor_past_pc,
  output logic            predictor_past_wrong,
  output logic            past_predicted_taken,
  output logic            past_is_branch,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            busy
`ifdef BRANCH_RESOLVER_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]             state;
  logic [FLUSH_CNT_W-1:0] cnt;

  logic isBranch;
  logic actualTaken;

  branch_cond_eval condEval (
    .opcode      (in_opcode),
    .opA         (in_opA),
    .opB         (in_opB),
    .is_branch   (isBranch),
    .actual_taken(actualTaken)
  );

  logic accepted;
  logic acceptedBranch;
  logic mispredict;

  assign accepted       = in_valid && (state == IDLE);
  assign acceptedBranch = accepted && isBranch;
  assign mispredict     = acceptedBranch && (actualTaken != in_predicted_taken);

  // flush/busy decode straight from the state register so an asserted reset
  // drops them immediately, not on the next edge.
  assign flush = (state == FLUSH);
  assign busy  = (state == FLUSH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      cnt                  <= '0;
      predictor_past_pc    <= '0;
      predictor_past_wrong <= 1'b0;
      past_predicted_taken <= 1'b0;
      past_is_branch       <= 1'b0;
      redirect_valid       <= 1'b0;
      redirect_pc          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      past_is_branch       <= acceptedBranch;
      predictor_past_wrong <= mispredict;
      redirect_valid       <= mispredict;

      if (accepted) begin
        predictor_past_pc    <= in_pc;
        past_predicted_taken <= in_predicted_taken;
      end

      // in_pc + 1 wraps naturally at PC_W bits.
      if (mispredict) begin
        redirect_pc <= actualTaken ? in_target : in_pc + PC_W'(1);
      end

      case (state)
        IDLE: begin
          if (mispredict) begin
            state <= FLUSH;
            cnt   <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_RESOLVER_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (acceptedBranch && (perf_branches != '1)) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (mispredict && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver (FLUSH_CYCLES=2, PC_W=32).
// The stimulus side pushes the hand-computed expected outputs for each clock
// edge; a monitor pops and compares them on the following falling edge.
module tb_branch_resolver;
  import branch_pkg::*;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_opcode;
  logic [31:0] in_pc;
  logic [31:0] in_opA;
  logic [31:0] in_opB;
  logic [31:0] in_target;
  logic        in_predicted_taken;
  logic [31:0] predictor_past_pc;
  logic        predictor_past_wrong;
  logic        past_predicted_taken;
  logic        past_is_branch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;
`ifdef BRANCH_RESOLVER_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  branch_resolver #(.FLUSH_CYCLES(2), .PC_W(32)) dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_opcode           (in_opcode),
    .in_pc               (in_pc),
    .in_opA              (in_opA),
    .in_opB              (in_opB),
    .in_target           (in_target),
    .in_predicted_taken  (in_predicted_taken),
    .predictor_past_pc   (predictor_past_pc),
    .predictor_past_wrong(predictor_past_wrong),
    .past_predicted_taken(past_predicted_taken),
    .past_is_branch      (past_is_branch),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .flush               (flush),
    .busy                (busy)
`ifdef BRANCH_RESOLVER_PERF_EN
    ,
    .perf_branches       (perf_branches),
    .perf_mispredicts    (perf_mispredicts)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    br_fb_t      fb;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    logic        bz;
  } exp_t;

  exp_t q[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    nCompared++;
    if (act !== expv) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input string n, input logic isBr, input logic wrong,
                              input logic [31:0] pc, input logic pred, input logic rv,
                              input logic [31:0] rpc, input logic fl, input logic bz);
    exp_t e;
    e.name = n;
    e.fb.pc = pc;
    e.fb.wrong = wrong;
    e.fb.predicted_taken = pred;
    e.fb.is_branch = isBr;
    e.rv = rv;
    e.rpc = rpc;
    e.fl = fl;
    e.bz = bz;
    return e;
  endfunction

  function automatic logic [127:0] pack_act();
    return {58'd0, past_is_branch, predictor_past_wrong, past_predicted_taken,
            redirect_valid, flush, busy, predictor_past_pc, redirect_pc};
  endfunction

  function automatic logic [127:0] pack_exp(input exp_t e);
    return {58'd0, e.fb.is_branch, e.fb.wrong, e.fb.predicted_taken,
            e.rv, e.fl, e.bz, e.fb.pc, e.rpc};
  endfunction

  // Monitor: compares the outputs produced by each edge half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, pack_act(), pack_exp(e));
      end
    end
  end

  task automatic drv(input logic v, input logic [4:0] op, input logic [31:0] pc,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] tgt, input logic pred);
    in_valid = v;
    in_opcode = op;
    in_pc = pc;
    in_opA = a;
    in_opB = b;
    in_target = tgt;
    in_predicted_taken = pred;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic step(input exp_t e);
    @(posedge clock);
    q.push_back(e);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    #1;
    check("reset_state", pack_act(), 128'd0);
    #1 reset = 1'b1;

    // bne equal operands predicted taken -> not taken, redirect pc+1.
    drv(1, OP_BNE, 32'h10, 32'd5, 32'd5, 32'h20, 1);
    step(mk("bne_mispredict", 1, 1, 32'h10, 1, 1, 32'h11, 1, 1));
    // Would-be mispredicts during flush are dropped.
    drv(1, OP_BNE, 32'h14, 32'd1, 32'd2, 32'h24, 0);
    step(mk("flush_ignore1", 0, 0, 32'h10, 1, 0, 32'h11, 1, 1));
    drv(1, OP_BLT, 32'h18, 32'hFFFFFFFF, 32'd1, 32'h28, 0);
    step(mk("flush_ignore2", 0, 0, 32'h10, 1, 0, 32'h11, 0, 0));
    // blt -1 < 1 taken, predicted not taken.
    drv(1, OP_BLT, 32'h30, 32'hFFFFFFFF, 32'd1, 32'h40, 0);
    step(mk("blt_neg_taken", 1, 1, 32'h30, 0, 1, 32'h40, 1, 1));
    idle();
    step(mk("blt_flush1", 0, 0, 32'h30, 0, 0, 32'h40, 1, 1));
    step(mk("blt_flush2", 0, 0, 32'h30, 0, 0, 32'h40, 0, 0));
    // blt max-positive vs min-negative: not taken (no overflow wrap).
    drv(1, OP_BLT, 32'h50, 32'h7FFFFFFF, 32'h80000000, 32'h60, 0);
    step(mk("blt_ovf_not_taken", 1, 0, 32'h50, 0, 0, 32'h40, 0, 0));
    drv(1, OP_BEX, 32'h54, 32'd0, 32'd0, 32'h70, 0);
    step(mk("bex_not_taken", 1, 0, 32'h54, 0, 0, 32'h40, 0, 0));
    drv(1, 5'b00000, 32'h58, 32'd9, 32'd9, 32'h0, 1);
    step(mk("add_non_branch", 0, 0, 32'h58, 1, 0, 32'h40, 0, 0));
    drv(1, OP_BEX, 32'h5C, 32'd3, 32'd0, 32'h80, 1);
    step(mk("bex_taken_ok", 1, 0, 32'h5C, 1, 0, 32'h40, 0, 0));
    // Not-taken redirect from the all-ones PC wraps to 0.
    drv(1, OP_BNE, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h90, 1);
    step(mk("pc_wrap", 1, 1, 32'hFFFFFFFF, 1, 1, 32'h0, 1, 1));
    idle();
    step(mk("wrap_flush1", 0, 0, 32'hFFFFFFFF, 1, 0, 32'h0, 1, 1));
    step(mk("wrap_flush2", 0, 0, 32'hFFFFFFFF, 1, 0, 32'h0, 0, 0));
    drv(1, OP_BLT, 32'h100, 32'd2, 32'd5, 32'h200, 0);
    step(mk("blt_pos_taken", 1, 1, 32'h100, 0, 1, 32'h200, 1, 1));
    idle();
    step(mk("pre_reset_flush1", 0, 0, 32'h100, 0, 0, 32'h200, 1, 1));

    // Asynchronous reset in the second flush cycle.
    @(negedge clock);
    #1 reset = 1'b0;
    #1 check("async_reset_drop", pack_act(), 128'd0);
    @(posedge clock);
    #1 check("reset_held", pack_act(), 128'd0);
    @(negedge clock);
    reset = 1'b1;

    // IDLE after release: a mispredict is accepted immediately.
    drv(1, OP_BNE, 32'h300, 32'd1, 32'd2, 32'h310, 0);
    step(mk("post_reset_accept", 1, 1, 32'h300, 0, 1, 32'h310, 1, 1));
    idle();
    step(mk("post_reset_flush1", 0, 0, 32'h300, 0, 0, 32'h310, 1, 1));
    step(mk("post_reset_flush2", 0, 0, 32'h300, 0, 0, 32'h310, 0, 0));
    drv(1, OP_BEX, 32'h320, 32'd0, 32'd0, 32'h330, 0);
    step(mk("bex_ok", 1, 0, 32'h320, 0, 0, 32'h310, 0, 0));
    drv(1, OP_BLT, 32'h324, 32'd1, 32'd2, 32'h334, 1);
    step(mk("blt_ok", 1, 0, 32'h324, 1, 0, 32'h310, 0, 0));
    idle();
    step(mk("idle_clear", 0, 0, 32'h324, 1, 0, 32'h310, 0, 0));

`ifdef BRANCH_RESOLVER_PERF_EN
    check("perf_counts", {64'd0, perf_branches, perf_mispredicts}, {64'd0, 32'd3, 32'd1});
    @(negedge clock);
    force dut.perf_branches = 32'hFFFFFFFE;
    force dut.perf_mispredicts = 32'hFFFFFFFE;
    #1;
    release dut.perf_branches;
    release dut.perf_mispredicts;
    for (int i = 0; i < 3; i++) begin
      drv(1, OP_BNE, 32'h400 + 32'(i * 4), 32'd1, 32'd2, 32'h500, 0);
      step(mk("perf_mis", 1, 1, 32'h400 + 32'(i * 4), 0, 1, 32'h500, 1, 1));
      idle();
      step(mk("perf_fl1", 0, 0, 32'h400 + 32'(i * 4), 0, 0, 32'h500, 1, 1));
      step(mk("perf_fl2", 0, 0, 32'h400 + 32'(i * 4), 0, 0, 32'h500, 0, 0));
    end
    check("perf_saturate", {64'd0, perf_branches, perf_mispredicts},
          {64'd0, 32'hFFFFFFFF, 32'hFFFFFFFF});
`endif

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    @(negedge clock);
    #1;
    nCompared++;
    if (q.size() != 0) begin
      nMismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
